// File: rtl/digdug_bus_pkg.sv
// Shared types and constants for the DigDug CPU-side bus arbiter.
package digdug_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAITRD, ACK} bus_state_t;

  localparam logic [1:0] CPU_MAIN = 2'd0;
  localparam logic [1:0] CPU_SUB  = 2'd1;
  localparam logic [1:0] CPU_SND  = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

endpackage

// File: rtl/digdug_rr_arb3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr, wrapping mod 3.
module digdug_rr_arb3
  import digdug_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [3:0] req4;
  logic [1:0] o0, o1, o2;

  assign req4 = {1'b0, req};

  always_comb begin
    o0 = CPU_MAIN;
    o1 = CPU_SUB;
    o2 = CPU_SND;
    case (ptr)
      CPU_SUB: begin o0 = CPU_SUB; o1 = CPU_SND;  o2 = CPU_MAIN; end
      CPU_SND: begin o0 = CPU_SND; o1 = CPU_MAIN; o2 = CPU_SUB;  end
      default: begin o0 = CPU_MAIN; o1 = CPU_SUB; o2 = CPU_SND;  end
    endcase
    valid = |req;
    idx   = GNT_NONE;
    if (req4[o0])      idx = o0;
    else if (req4[o1]) idx = o1;
    else if (req4[o2]) idx = o2;
  end

endmodule

// File: rtl/digdug_cpu_busarb.sv
// Arbitrates the main/sub/sound Z80 accesses onto the single I/O device bus and
// returns completion strobes and read data to the owning CPU.
module digdug_cpu_busarb
  import digdug_bus_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int          DW       = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [DW-1:0] OPEN_BUS = {DW{1'b1}}
) (
  input  logic          clkdiv,
  input  logic          RESET,
  input  logic [2:0]    RSTS,
  input  logic [2:0]    REQ,
  input  logic [2:0]    REQWR,
  input  logic [AW-1:0] REQAD0,
  input  logic [AW-1:0] REQAD1,
  input  logic [AW-1:0] REQAD2,
  input  logic [DW-1:0] REQDI0,
  input  logic [DW-1:0] REQDI1,
  input  logic [DW-1:0] REQDI2,
  output logic [2:0]    ACK,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] AD,
  output logic          WR,
  output logic [DW-1:0] DI,
  output logic          RD,
  input  logic          DV,
  input  logic [DW-1:0] DO,
  output logic [1:0]    GNT
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("digdug_cpu_busarb: RD_LAT must be in 1..3");
  end

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  bus_state_t    state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, cnt, cnt_nxt, gnt_nxt;
  logic          is_wr, is_wr_nxt, abort, abort_nxt, wr_nxt, rd_nxt, lost;
  logic [2:0]    ack_nxt;
  logic [AW-1:0] ad_nxt, pick_ad;
  logic [DW-1:0] di_nxt, rdata_nxt, pick_di;
  logic [3:0]    req4, rsts4, reqwr4;
  logic          pick_valid;
  logic [1:0]    pick_idx;

  assign req4   = {1'b0, REQ};
  assign rsts4  = {1'b0, RSTS};
  assign reqwr4 = {1'b0, REQWR};

  digdug_rr_arb3 u_arb (
    .req   (REQ & ~RSTS),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    case (pick_idx)
      CPU_SUB: begin pick_ad = REQAD1; pick_di = REQDI1; end
      CPU_SND: begin pick_ad = REQAD2; pick_di = REQDI2; end
      default: begin pick_ad = REQAD0; pick_di = REQDI0; end
    endcase
  end

  // The owner losing its request or entering reset mid-transfer only suppresses the
  // CPU-side completion; the bus cycle itself always runs to the end.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    is_wr_nxt = is_wr;
    abort_nxt = abort;
    ad_nxt    = AD;
    di_nxt    = DI;
    wr_nxt    = 1'b0;
    rd_nxt    = RD;
    gnt_nxt   = GNT;
    ack_nxt   = 3'b000;
    rdata_nxt = RDATA;
    lost      = rsts4[GNT] | ~req4[GNT];
    case (state)
      IDLE: begin
        gnt_nxt = GNT_NONE;
        if (pick_valid) begin
          state_nxt = ISSUE;
          gnt_nxt   = pick_idx;
          ad_nxt    = pick_ad;
          di_nxt    = pick_di;
          is_wr_nxt = reqwr4[pick_idx];
          wr_nxt    = reqwr4[pick_idx];
          rd_nxt    = ~reqwr4[pick_idx];
          abort_nxt = 1'b0;
        end
      end
      ISSUE: begin
        abort_nxt = abort | lost;
        if (is_wr) begin
          state_nxt = digdug_bus_pkg::ACK;
          if (!abort_nxt) ack_nxt = 3'b001 << GNT;
        end else begin
          state_nxt = WAITRD;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAITRD: begin
        abort_nxt = abort | lost;
        if (cnt == 2'd0) begin
          state_nxt = digdug_bus_pkg::ACK;
          rd_nxt    = 1'b0;
          if (!abort_nxt) begin
            ack_nxt   = 3'b001 << GNT;
            rdata_nxt = DV ? DO : OPEN_BUS;
          end
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      digdug_bus_pkg::ACK: begin
        ptr_nxt   = (GNT == CPU_SND) ? CPU_MAIN : GNT + 2'd1;
        gnt_nxt   = GNT_NONE;
        rd_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= CPU_MAIN;
      cnt   <= 2'd0;
      is_wr <= 1'b0;
      abort <= 1'b0;
      AD    <= '0;
      DI    <= '0;
      WR    <= 1'b0;
      RD    <= 1'b0;
      GNT   <= GNT_NONE;
      ACK   <= 3'b000;
      RDATA <= OPEN_BUS;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      is_wr <= is_wr_nxt;
      abort <= abort_nxt;
      AD    <= ad_nxt;
      DI    <= di_nxt;
      WR    <= wr_nxt;
      RD    <= rd_nxt;
      GNT   <= gnt_nxt;
      ACK   <= ack_nxt;
      RDATA <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_digdug_cpu_busarb.sv
// Bench for digdug_cpu_busarb: directed scenarios plus random CPU traffic, all checked
// against a per-transfer timeline model of the bus.
module tb_digdug_cpu_busarb;

  localparam int RD_LAT = 1;

  logic        clkdiv = 1'b0;
  logic        RESET;
  logic [2:0]  RSTS, REQ, REQWR;
  logic [15:0] cpu_ad [3];
  logic [7:0]  cpu_di [3];
  logic [2:0]  ACK;
  logic [7:0]  RDATA, DI, DO;
  logic [15:0] AD;
  logic        WR, RD, DV;
  logic [1:0]  GNT;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the transfer in flight: grant cycle, ACK cycle and the latched request.
  int          cyc, n_start, ack_at, m_cpu, m_ptr;
  bit          m_active, m_wr, m_lost, hold_req;
  logic [15:0] m_ad;
  logic [7:0]  m_di, m_rdata;
  logic [2:0]  ack_exp;

  always #5 clkdiv = ~clkdiv;

  digdug_cpu_busarb #(.AW(16), .DW(8), .RD_LAT(RD_LAT), .OPEN_BUS(8'hFF)) dut (
    .clkdiv (clkdiv),
    .RESET  (RESET),
    .RSTS   (RSTS),
    .REQ    (REQ),
    .REQWR  (REQWR),
    .REQAD0 (cpu_ad[0]),
    .REQAD1 (cpu_ad[1]),
    .REQAD2 (cpu_ad[2]),
    .REQDI0 (cpu_di[0]),
    .REQDI1 (cpu_di[1]),
    .REQDI2 (cpu_di[2]),
    .ACK    (ACK),
    .RDATA  (RDATA),
    .AD     (AD),
    .WR     (WR),
    .DI     (DI),
    .RD     (RD),
    .DV     (DV),
    .DO     (DO),
    .GNT    (GNT)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, expv);
  endtask

  task automatic model_reset();
    cyc = 0; n_start = 0; ack_at = 0; m_cpu = 0; m_ptr = 0;
    m_active = 0; m_wr = 0; m_lost = 0;
    m_ad = '0; m_di = '0; m_rdata = 8'hFF; ack_exp = '0;
  endtask

  // Check one cycle on the falling edge, advance the model, then move past the next rising edge.
  task automatic run_cycle();
    bit         in_xfer;
    logic [2:0] e_ack, elig;
    int         pick;
    @(negedge clkdiv);
    in_xfer = m_active && cyc > n_start && cyc <= ack_at;
    e_ack   = (in_xfer && cyc == ack_at && !m_lost) ? 3'(1 << m_cpu) : 3'b000;
    checkOutput("gnt", 32'(GNT), in_xfer ? m_cpu : 3);
    checkOutput("wr", 32'(WR), 32'(in_xfer && m_wr && cyc == n_start + 1));
    checkOutput("rd", 32'(RD), 32'(in_xfer && !m_wr && cyc >= n_start + 1 && cyc <= n_start + 1 + RD_LAT));
    checkOutput("ack", 32'(ACK), 32'(e_ack));
    checkOutput("ad", 32'(AD), 32'(m_ad));
    checkOutput("di", 32'(DI), 32'(m_di));
    checkOutput("rdata", 32'(RDATA), 32'(m_rdata));
    ack_exp = e_ack;
    if (in_xfer && cyc < ack_at) begin
      m_lost = m_lost || RSTS[m_cpu] || !REQ[m_cpu];
      if (!m_wr && cyc == ack_at - 1 && !m_lost) m_rdata = DV ? DO : 8'hFF;
    end
    if (in_xfer && cyc == ack_at) begin
      m_ptr    = (m_cpu + 1) % 3;
      m_active = 0;
    end else if (!m_active) begin
      elig = REQ & ~RSTS;
      pick = -1;
      for (int k = 0; k < 3; k++)
        if (pick < 0 && elig[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
      if (pick >= 0) begin
        m_active = 1; m_cpu = pick; n_start = cyc; m_lost = 0;
        m_wr   = REQWR[pick];
        m_ad   = cpu_ad[pick];
        m_di   = cpu_di[pick];
        ack_at = cyc + (m_wr ? 2 : 2 + RD_LAT);
      end
    end
    cyc++;
    @(posedge clkdiv);
    #1;
    if (!hold_req) REQ = REQ & ~ack_exp;
  endtask

  task automatic drain();
    REQ = 3'b000;
    for (int i = 0; i < 12; i++) run_cycle();
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 3; i++) begin
      if (!REQ[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          REQ[i]    = 1'b1;
          REQWR[i]  = 1'($urandom_range(0, 1));
          cpu_ad[i] = 16'($urandom);
          cpu_di[i] = 8'($urandom);
        end
      end else if ($urandom_range(0, 39) == 0) begin
        REQ[i] = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        cpu_ad[i] = 16'($urandom);
      end
      if ($urandom_range(0, 24) == 0) RSTS[i] = ~RSTS[i];
    end
    DO = 8'($urandom);
    DV = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    RESET = 1'b1; RSTS = '0; REQ = '0; REQWR = '0; DV = 1'b1; DO = '0; hold_req = 0;
    for (int i = 0; i < 3; i++) begin cpu_ad[i] = '0; cpu_di[i] = '0; end
    model_reset();
    #2;
    checkOutput("rst_gnt", 32'(GNT), 3);
    checkOutput("rst_rdata", 32'(RDATA), 32'hFF);
    @(posedge clkdiv); @(posedge clkdiv); #1;
    RESET = 1'b0;

    // Main CPU reads $8000 from the device, data 5A.
    cpu_ad[0] = 16'h8000; REQWR[0] = 1'b0; DO = 8'h5A; DV = 1'b1; REQ[0] = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle();
    checkOutput("t1_rdata", 32'(RDATA), 32'h5A);

    // Sub CPU writes 01 to $A003.
    cpu_ad[1] = 16'hA003; cpu_di[1] = 8'h01; REQWR[1] = 1'b1; REQ[1] = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle();

    // All three request continuously; grants rotate and ACKs never overlap.
    hold_req = 1;
    REQWR = 3'b010; cpu_ad[0] = 16'h1000; cpu_ad[2] = 16'h3000; REQ = 3'b111;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      checkOutput("t3_onehot", 32'($countones(ACK) > 1), 0);
    end
    hold_req = 0;
    drain();

    // Sound CPU reads $5000 with no device responding.
    cpu_ad[2] = 16'h5000; REQWR[2] = 1'b0; DV = 1'b0; DO = 8'h33; REQ[2] = 1'b1;
    for (int i = 0; i < 7; i++) run_cycle();
    checkOutput("t4_rdata", 32'(RDATA), 32'hFF);
    DV = 1'b1;

    // Sub CPU enters reset during its write ISSUE cycle; the bus then goes to the sound CPU.
    cpu_ad[1] = 16'hA005; cpu_di[1] = 8'h77; REQWR[1] = 1'b1;
    cpu_ad[2] = 16'h5001; REQWR[2] = 1'b0;
    REQ = 3'b110;
    run_cycle();
    RSTS = 3'b010;
    for (int i = 0; i < 3; i++) run_cycle();
    checkOutput("t5_gnt", 32'(GNT), 2);
    for (int i = 0; i < 4; i++) run_cycle();
    RSTS = 3'b000;
    drain();

    // Reset arrives while a main CPU read is waiting for data.
    cpu_ad[0] = 16'h1234; REQWR[0] = 1'b0; REQ = 3'b001;
    run_cycle();
    run_cycle();
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("t6_rd", 32'(RD), 0);
    checkOutput("t6_gnt", 32'(GNT), 3);
    checkOutput("t6_ack", 32'(ACK), 0);
    checkOutput("t6_wr", 32'(WR), 0);
    checkOutput("t6_ad", 32'(AD), 0);
    @(posedge clkdiv); #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) run_cycle();
    drain();

    for (int n = 0; n < 800; n++) begin
      applyStimulus();
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
